// File: rtl/mdu_if.sv
// Request/response bundle between the issue stage and the iterative multiply/divide unit.
// The master drives the operands and strobes; the slave returns status and the writeback data.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  modport master (
    output start, op, a, b, rd_in, abort,
    input  busy, done, result, rd_out, dbg_state
  );

  modport slave (
    input  start, op, a, b, rd_in, abort,
    output busy, done, result, rd_out, dbg_state
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Define MDU_DIV_EN to build the divider; without it, ops 100-111 complete at once with result 0.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);
  localparam int W = WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [5:0] LAST_ITER = 6'd31;

  logic [1:0]     state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [4:0]     rd_pend_q, rd_pend_d;
  logic [W-1:0]   result_q, result_d;
  logic [4:0]     rd_out_q, rd_out_d;

  // Handshake: start is a request strobe taken only in IDLE or DONE and never in a cycle
  // where abort is high; done is a one-cycle valid for result/rd_out with no back-pressure.
  logic         can_accept;
  logic         accept;
  logic         is_div;
  logic         a_signed;
  logic         b_signed;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic         fast;
  logic [W-1:0] fast_res;

  always_comb begin
    can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    accept     = bus.start && can_accept && !bus.abort;
    is_div     = bus.op[2];
    a_signed   = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                 (bus.op == 3'b100) || (bus.op == 3'b110);
    b_signed   = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    a_neg      = a_signed && bus.a[W-1];
    b_neg      = b_signed && bus.b[W-1];
    a_mag      = a_neg ? -bus.a : bus.a;
    b_mag      = b_neg ? -bus.b : bus.b;
  end

`ifdef MDU_DIV_EN
  logic         b_zero;
  logic         div_ovf;
  logic [W-1:0] int_min;

  always_comb begin
    int_min  = {1'b1, {(W-1){1'b0}}};
    b_zero   = (bus.b == '0);
    // Signed overflow (INT_MIN / -1) only exists for DIV and REM, which have op[0] clear.
    div_ovf  = !bus.op[0] && (bus.a == int_min) && (bus.b == '1);
    fast     = is_div && (b_zero || div_ovf);
    if (b_zero) begin
      fast_res = bus.op[1] ? bus.a : '1;
    end else begin
      fast_res = bus.op[1] ? '0 : int_min;
    end
  end
`else
  always_comb begin
    fast     = is_div;
    fast_res = '0;
  end
`endif

  // Multiply step: add the multiplicand into the upper half when the low multiplier bit is set,
  // then shift the whole accumulator right; after W steps it holds the full product.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_step = {mul_sum, acc_q[W-1:1]};
  end

`ifdef MDU_DIV_EN
  // Divide step: upper half is the partial remainder, lower half shifts the dividend out
  // while quotient bits shift in.
  logic [W:0]     rem_sh;
  logic [W:0]     rem_diff;
  logic [2*W-1:0] div_step;

  always_comb begin
    rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    rem_diff = rem_sh - {1'b0, mcand_q};
    if (!rem_diff[W]) begin
      div_step = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_step = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end
`endif

  logic [2*W-1:0] prod_s;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod_s  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*W-1:W];
`ifdef MDU_DIV_EN
      3'b100, 3'b101:         fix_res = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
      3'b110, 3'b111:         fix_res = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
`endif
      default:                fix_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    rd_pend_d = rd_pend_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d      = bus.op;
          sa_d      = a_neg;
          sb_d      = b_neg;
          rd_pend_d = bus.rd_in;
          cnt_d     = '0;
          mcand_d   = is_div ? b_mag : a_mag;
          acc_d     = {{W{1'b0}}, (is_div ? a_mag : b_mag)};
          if (fast) begin
            state_d  = ST_DONE;
            result_d = fast_res;
            rd_out_d = bus.rd_in;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
`ifdef MDU_DIV_EN
        acc_d = op_q[2] ? div_step : mul_step;
`else
        acc_d = mul_step;
`endif
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d  = ST_DONE;
        result_d = fix_res;
        rd_out_d = rd_pend_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush wins over everything except reset and leaves the last writeback untouched.
    if (bus.abort) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      rd_pend_q <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      rd_pend_q <= rd_pend_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.rd_out    = rd_out_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed cases from the RV32M rules plus randomized traffic,
// all checked against an arithmetic reference model; honours MDU_DIV_EN like the design.
module tb_mdu_iterative;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_if bus();

  mdu_iterative #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] up;
`ifdef MDU_DIV_EN
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    up = {32'h0, a} * {32'h0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return up[63:32];
      default: ;
    endcase
`ifdef MDU_DIV_EN
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      3'd4: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : ia / ib;
      3'd5: return a / b;
      3'd6: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : ia % ib;
      default: return a % b;
    endcase
`else
    return 32'h0;
`endif
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!op[2]) return 34;
`ifdef MDU_DIV_EN
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
`else
    return 1;
`endif
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [W-1:0] exp_q[$];
  logic [4:0]   exp_rd_q[$];
  logic         m_act = 1'b0;
  logic         chk_en = 1'b0;
  int           m_end = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  logic [31:0]  m_res;
  logic [4:0]   m_rd;

  always @(negedge clk) begin
    logic e_done;
    if (chk_en) begin
      e_done = m_act && (cyc == m_end);
      if (e_done && exp_q.size() > 0) begin
        m_res = exp_q.pop_front();
        m_rd  = exp_rd_q.pop_front();
      end
      check("busy",   {31'h0, bus.busy}, {31'h0, m_act});
      check("done",   {31'h0, bus.done}, {31'h0, e_done});
      check("result", bus.result, m_res);
      check("rd_out", {27'h0, bus.rd_out}, {27'h0, m_rd});
    end
    if (bus.done) done_cnt++;
    if (rst) begin
      m_act = 1'b0;
      exp_q.delete();
      exp_rd_q.delete();
      m_res  = 32'h0;
      m_rd   = 5'h0;
      chk_en = 1'b1;
    end else if (bus.abort) begin
      m_act = 1'b0;
      exp_q.delete();
      exp_rd_q.delete();
    end else if (bus.start && (!m_act || cyc == m_end)) begin
      m_act = 1'b1;
      m_end = cyc + ref_lat(bus.op, bus.a, bus.b);
      exp_q.push_back(ref_res(bus.op, bus.a, bus.b));
      exp_rd_q.push_back(bus.rd_in);
    end else if (m_act && cyc == m_end) begin
      m_act = 1'b0;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.rd_in = rd;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
    end
    res = bus.result;
    rdo = bus.rd_out;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
    int          lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    check({name, "_model"}, ref_res(op, a, b), exp_res);
    run_op(op, a, b, rd, lat, res, rdo);
    check({name, "_res"}, res, exp_res);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_rd"}, {27'h0, rdo}, {27'h0, rd});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      4:       return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    int          dc;
    logic [31:0] res;
    logic [4:0]  rdo;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    bus.rd_in = 5'd0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy",   {31'h0, bus.busy}, 32'h0);
    check("rst_done",   {31'h0, bus.done}, 32'h0);
    check("rst_result", bus.result, 32'h0);
    check("rst_rd",     {27'h0, bus.rd_out}, 32'h0);
    tick();

    // Multiply; each follows the previous in its DONE cycle (back-to-back).
    directed("mul",   3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34);
    directed("mulh",  3'd1, 32'd7, 32'hFFFF_FFFD, 5'd6, 32'hFFFF_FFFF, 34);
    directed("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 34);
    directed("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 34);

`ifdef MDU_DIV_EN
    directed("div",     3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9,  32'hFFFF_FFFA, 34);
    directed("rem",     3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFE, 34);
    directed("divu",    3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 34);
    directed("remu",    3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 34);
    directed("div0",    3'd4, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    directed("remu0",   3'd7, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    directed("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    directed("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 1);
`else
    directed("div_off",  3'd5, 32'd100, 32'd7, 5'd11, 32'd0, 1);
    directed("rem_off",  3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'd0, 1);
    directed("div0_off", 3'd4, 32'd5, 32'd0, 5'd13, 32'd0, 1);
`endif
    directed("mul67", 3'd0, 32'd6, 32'd7, 5'd17, 32'd42, 34);
    tick();
    tick();

    // start during CALC is ignored
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5; bus.rd_in = 5'd3;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.rd_in = 5'd9;
    tick();
    bus.start = 1'b0;
    lat = 7;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
    end
    check("ign_lat", lat, 34);
    check("ign_res", bus.result, 32'd15);
    check("ign_rd",  {27'h0, bus.rd_out}, 32'd3);
    tick();
    check("ign_idle", {31'h0, bus.busy}, 32'h0);
    tick();

    // abort at N+10
    dc = done_cnt;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd9; bus.b = 32'd9; bus.rd_in = 5'd20;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", {31'h0, bus.busy}, 32'h0);
    repeat (40) tick();
    check("abort_nodone", done_cnt, dc);
    check("abort_res", bus.result, 32'd15);
    check("abort_rd",  {27'h0, bus.rd_out}, 32'd3);

    // start together with abort is dropped
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_start", {31'h0, bus.busy}, 32'h0);

    // reset mid-operation
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd11; bus.b = 32'd13; bus.rd_in = 5'd21;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("mid_rst_res",  bus.result, 32'h0);
    check("mid_rst_rd",   {27'h0, bus.rd_out}, 32'h0);
    tick();

    // randomized traffic; the compare process checks every cycle
    repeat (150) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      if ($urandom_range(0, 9) == 0) begin
        bus.start = 1'b1; bus.op = rop; bus.a = ra; bus.b = rb;
        bus.rd_in = 5'($urandom_range(0, 31));
        tick();
        bus.start = 1'b0;
        repeat ($urandom_range(0, 36)) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
      end else begin
        run_op(rop, ra, rb, 5'($urandom_range(0, 31)), lat, res, rdo);
        check("rand_lat", lat, ref_lat(rop, ra, rb));
        check("rand_res", res, ref_res(rop, ra, rb));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Iterative RV32M multiply/divide unit sitting directly downstream of the register file. It consumes the rs1/rs2 read data (RD1/RD2) and funct3 of an M-extension instruction and computes one radix-2 step per cycle. It returns a 32-bit result plus the destination register tag for writeback to the register file write port (A3/WD3/WE3). Fast paths handle the architecturally defined divide corner cases.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only in IDLE or DONE.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  32  rs1 operand (register file RD1).
- b  in  32  rs2 operand (register file RD2).
- rd_in  in  5  destination register index.
- abort  in  1  pipeline flush; cancels the operation in flight.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result/rd_out are valid in this cycle.
- result  out  32  registered result; held until the next completion.
- rd_out  out  5  registered copy of rd_in captured at accept.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept (start=1 in IDLE/DONE):
  - Latch op, rd_in, and operand magnitudes.
  - Latch sign flags: signed a for MULH/MULHSU/DIV/REM; signed b for MULH/DIV/REM.
  - Clear the 6-bit iteration counter.
  - Go to CALC, or straight to DONE on a fast path.
- CALC:
  - Multiply: shift-add on |a|×|b| into a 64-bit accumulator.
  - Divide: restoring division on |a|/|b|, producing a 32-bit quotient and 32-bit remainder.
  - Exactly 32 iterations, then go to FIX.
- FIX:
  - Negate the product if sa^sb.
  - DIV: negate the quotient if sa^sb. REM: remainder takes the sign of a.
  - Select the output: MUL gives product[31:0]; MULH/MULHSU/MULHU give product[63:32].
  - Register result, go to DONE.
- DONE: done=1 for this cycle; next state is CALC or DONE if start is accepted, else IDLE.
- Fast paths, with no CALC:
  - b==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - DIV/REM with a=0x80000000, b=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- start while in CALC/FIX is ignored; no queueing.
- abort:
  - Priority is rst > abort > start.
  - Next state is IDLE, done does not pulse, and result/rd_out keep their old values.
  - A start in the same cycle as abort is dropped.
- Reset: state IDLE, busy=0, done=0, result=0, rd_out=0, counter=0.

## Timing
- Iterative op, start accepted in cycle N:
  - busy high N+1..N+34.
  - CALC N+1..N+32, FIX N+33, DONE N+34 (done=1).
- Fast path: DONE in N+1 (done=1), busy high in N+1 only.
- Back-to-back: start accepted in a DONE cycle makes that op's first CALC cycle the next cycle; busy stays high.
- result and rd_out change only on the clock edge that enters DONE.
- Reset mid-operation: the next cycle is IDLE with all outputs at their reset values.

## Configuration
- MDU_DIV_EN:
  - Defined: divider datapath and ops 100–111 are fully implemented as above.
  - Undefined: divider logic is compiled out. Ops 100–111 take the fast path, returning result=0 with done in N+1. Multiply behaviour is unchanged.

## Test plan
- Reset: rst=1 for 2 cycles, then start=0 -> busy=0, done=0, result=0, rd_out=0.
- Multiply:
  - MUL a=7, b=0xFFFFFFFD, rd_in=5 -> done at N+34, result=0xFFFFFFEB, rd_out=5.
  - MULH on the same operands -> 0xFFFFFFFF.
  - MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- Divide:
  - DIV a=0xFFFFFFEC (−20), b=3 -> 0xFFFFFFFA.
  - REM on the same operands -> 0xFFFFFFFE.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Corners:
  - DIV 5/0 -> 0xFFFFFFFF with done at N+1; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
- Handshake:
  - start during CALC -> ignored, and the first result is unchanged.
  - abort at N+10 -> busy=0 at N+11, no done pulse.
  - start in a DONE cycle -> second done exactly 34 cycles later.
- Config, MDU_DIV_EN undefined: DIV 100/7 -> done at N+1, result=0; MUL 6×7 -> 42 at N+34.
